sprite_store_scan: RTL and testbench

Parametrised successor to the fixed 10-slot sprite control logic. Scans OAM once per line and stores up to SLOTS sprites that intersect the current line, recording X, OAM index and row-in-sprite for each. During pixel output it reports the highest-priority stored sprite whose X matches the pixel counter, and holds that hit until the fetcher acknowledges it. Sits between the OAM read port and the sprite fetcher/pixel pipeline.

---
 rtl/sprite_store_scan.sv | 158 +++++++++++++++
 tb/tb_sprite_store_scan.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_store_scan.sv
// Per-line OAM scan into a small sprite store, then X-match against the pixel
// counter, holding the winning hit until the fetcher acknowledges it.
module sprite_store_scan #(
    parameter int SLOTS       = 10,
    parameter int OAM_ENTRIES = 40,
    parameter int IDXW        = 6,
    parameter int CNTW        = 4
) (
    input  logic            clk1,
    input  logic            nreset_video,
    input  logic            line_start,
    input  logic [7:0]      ly,
    input  logic            tall,
    input  logic            obj_en,
    output logic [IDXW-1:0] oam_idx,
    input  logic [7:0]      oam_y,
    input  logic [7:0]      oam_x,
    output logic            scanning,
    output logic            scan_done,
    output logic [CNTW-1:0] count,
    output logic            full,
    input  logic [7:0]      px_x,
    input  logic            px_valid,
    output logic            hit,
    output logic [IDXW-1:0] hit_idx,
    output logic [3:0]      hit_row,
    input  logic            fetch_done
);
    typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;
    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [3:0]      row;
    } hit_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(OAM_ENTRIES - 1);
    localparam logic [CNTW-1:0] SLOTS_C  = CNTW'(SLOTS);

    state_t                     state, state_d;
    logic [1:0]                 vld_pipe;  // [0] address issued, [1] oam_y/oam_x valid
    logic [IDXW-1:0]            cmp_idx;
    logic [7:0]                 row_full;
    logic [3:0]                 store_row;
    logic                       in_range, store, scan_last, ack, hit_c;
    logic [CNTW-1:0]            hit_slot, win_slot;
    hit_t                       win;
    logic [SLOTS-1:0]           slot_match, slot_wr, slot_inval;
    logic [SLOTS-1:0][IDXW-1:0] slot_idx;
    logic [SLOTS-1:0][3:0]      slot_row;

    assign row_full  = ly + 8'd16 - oam_y;
    assign in_range  = tall ? (row_full < 8'd16) : (row_full < 8'd8);
    assign store_row = {tall & row_full[3], row_full[2:0]};
    assign scan_last = (state == SCAN) && vld_pipe[1] && (cmp_idx == LAST_IDX);
    assign store     = (state == SCAN) && vld_pipe[1] && in_range && !full && !line_start;
    assign ack       = (state == READY) && hit && fetch_done && !line_start;
    assign scanning  = (state == SCAN);
    assign full      = (count == SLOTS_C);

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        logic            vld;
        logic [7:0]      x;
        logic [IDXW-1:0] idx;
        logic [3:0]      row;

        assign slot_wr[i]    = store && (count == CNTW'(i));
        assign slot_inval[i] = ack && (hit_slot == CNTW'(i));

        always_ff @(posedge clk1) begin
            if (!nreset_video) begin
                vld <= 1'b0;
                x   <= '0;
                idx <= '0;
                row <= '0;
            end else if (line_start) begin
                vld <= 1'b0;
            end else if (slot_wr[i]) begin
                vld <= 1'b1;
                x   <= oam_x;
                idx <= cmp_idx;
                row <= store_row;
            end else if (slot_inval[i]) begin
                vld <= 1'b0;
            end
        end

        assign slot_match[i] = vld && (x == px_x);
        assign slot_idx[i]   = idx;
        assign slot_row[i]   = row;
    end

    // Slots fill in scan order, so the lowest matching slot is the lowest OAM index.
    always_comb begin
        hit_c    = 1'b0;
        win_slot = '0;
        win      = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_match[i]) begin
                hit_c    = 1'b1;
                win_slot = CNTW'(i);
                win.idx  = slot_idx[i];
                win.row  = slot_row[i];
            end
        end
        hit_c = hit_c && obj_en && px_valid;
    end

    always_ff @(posedge clk1) begin
        if (!nreset_video) state <= IDLE;
        else               state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (line_start)     state_d = SCAN;
        else if (scan_last) state_d = READY;
    end

    always_ff @(posedge clk1) begin
        if (!nreset_video) begin
            vld_pipe  <= '0;
            oam_idx   <= '0;
            cmp_idx   <= '0;
            count     <= '0;
            scan_done <= 1'b0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            hit_row   <= '0;
            hit_slot  <= '0;
        end else if (line_start) begin
            vld_pipe  <= 2'b01;
            oam_idx   <= '0;
            count     <= '0;
            scan_done <= 1'b0;
            hit       <= 1'b0;
        end else begin
            scan_done   <= scan_last;
            cmp_idx     <= oam_idx;
            vld_pipe[1] <= vld_pipe[0];
            vld_pipe[0] <= vld_pipe[0] && (oam_idx != LAST_IDX);
            if (vld_pipe[0] && (oam_idx != LAST_IDX))
                oam_idx <= oam_idx + IDXW'(1);
            if (store)
                count <= count + CNTW'(1);
            if (ack) begin
                hit <= 1'b0;
            end else if (state == READY) begin
                if (!obj_en) begin
                    hit <= 1'b0;
                end else if (!hit && hit_c) begin
                    hit      <= 1'b1;
                    hit_idx  <= win.idx;
                    hit_row  <= win.row;
                    hit_slot <= win_slot;
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_store_scan.sv
// Directed bench for sprite_store_scan: a reference model of the line scan
// fills a scoreboard of expected hits that a pixel sweep drains.
module tb_sprite_store_scan;
    localparam int SLOTS = 10, OAM_ENTRIES = 40, IDXW = 6, CNTW = 4;

    logic            clk1 = 1'b0, nreset_video = 1'b0, line_start = 1'b0;
    logic            tall = 1'b0, obj_en = 1'b1, px_valid = 1'b0, fetch_done = 1'b0;
    logic [7:0]      ly = 8'd0, px_x = 8'd0, oam_y, oam_x;
    logic [IDXW-1:0] oam_idx, hit_idx;
    logic [CNTW-1:0] count;
    logic            scanning, scan_done, full, hit;
    logic [3:0]      hit_row;

    logic [7:0] oy [64];
    logic [7:0] ox [64];
    int checks = 0, failures = 0;

    typedef struct packed {
        logic [7:0]      x;
        logic [IDXW-1:0] idx;
        logic [3:0]      row;
    } ent_t;
    ent_t stored[$];
    ent_t exp_q[$];

    sprite_store_scan #(.SLOTS(SLOTS), .OAM_ENTRIES(OAM_ENTRIES), .IDXW(IDXW), .CNTW(CNTW)) dut (
        .clk1(clk1), .nreset_video(nreset_video), .line_start(line_start), .ly(ly),
        .tall(tall), .obj_en(obj_en), .oam_idx(oam_idx), .oam_y(oam_y), .oam_x(oam_x),
        .scanning(scanning), .scan_done(scan_done), .count(count), .full(full),
        .px_x(px_x), .px_valid(px_valid), .hit(hit), .hit_idx(hit_idx),
        .hit_row(hit_row), .fetch_done(fetch_done)
    );

    always #5 clk1 = ~clk1;

    // OAM read port with one cycle of latency
    always @(posedge clk1) begin
        oam_y <= oy[oam_idx];
        oam_x <= ox[oam_idx];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 64; i++) begin
            oy[i] = 8'd0;
            ox[i] = 8'd200;
        end
    endtask

    // Reference: which entries land in the store for the current ly/tall
    task automatic model_scan();
        logic [7:0] r;
        ent_t e;
        stored.delete();
        for (int i = 0; i < OAM_ENTRIES; i++) begin
            r = ly + 8'd16 - oy[i];
            if ((tall ? (r < 8'd16) : (r < 8'd8)) && stored.size() < SLOTS) begin
                e.x   = ox[i];
                e.idx = IDXW'(i);
                e.row = r[3:0];
                stored.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (scan_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_scan_latency"}, n, OAM_ENTRIES + 1);
        chk({tag, "_count"}, count, stored.size());
        chk({tag, "_full"}, full, stored.size() == SLOTS);
        tick();
        chk({tag, "_done_pulse"}, scan_done, 0);
        chk({tag, "_scan_end"}, scanning, 0);
    endtask

    task automatic do_scan(input string tag);
        model_scan();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk({tag, "_scanning"}, scanning, 1);
        chk({tag, "_idx0"}, oam_idx, 0);
        wait_done(tag);
    endtask

    // Sweep px_x upward; every hit is popped from the scoreboard and acknowledged.
    task automatic sweep(input string tag);
        ent_t e;
        int guard;
        exp_q.delete();
        for (int v = 0; v < 256; v++)
            foreach (stored[k])
                if (stored[k].x == 8'(v)) exp_q.push_back(stored[k]);
        px_valid = 1'b1;
        for (int v = 0; v < 256; v++) begin
            px_x = 8'(v);
            tick();
            guard = 0;
            while (hit === 1'b1 && guard < SLOTS + 2) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_hit"}, hit, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "_hit_x"}, px_x, e.x);
                    chk({tag, "_hit_idx"}, hit_idx, e.idx);
                    chk({tag, "_hit_row"}, hit_row, e.row);
                end
                fetch_done = 1'b1;
                tick();
                fetch_done = 1'b0;
                chk({tag, "_hit_drop"}, hit, 0);
                tick();
                guard++;
            end
        end
        px_valid = 1'b0;
        chk({tag, "_missed_hits"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        clear_oam();
        repeat (3) tick();
        chk("rst_oam_idx", oam_idx, 0);
        chk("rst_scanning", scanning, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_hit", hit, 0);
        chk("rst_hit_idx", hit_idx, 0);
        chk("rst_hit_row", hit_row, 0);
        nreset_video = 1'b1;
        tick();

        // single short sprite, row 6
        ly = 8'd20;
        tall = 1'b0;
        oy[3] = 8'd30; ox[3] = 8'd40;
        do_scan("t1");
        sweep("t1");

        // row 14 entry only kept for tall sprites
        oy[5] = 8'd22; ox[5] = 8'd60;
        tall = 1'b1;
        do_scan("t2_tall");
        sweep("t2_tall");
        tall = 1'b0;
        do_scan("t2_short");
        sweep("t2_short");

        // overflow: twelve in range, ten stored
        clear_oam();
        for (int i = 0; i < 12; i++) begin
            oy[i] = 8'(36 - (i % 8));
            ox[i] = 8'(20 + 3 * i);
        end
        do_scan("t3");
        sweep("t3");

        // two sprites at the same X, served in slot order
        clear_oam();
        oy[2] = 8'd30; ox[2] = 8'd50;
        oy[7] = 8'd33; ox[7] = 8'd50;
        do_scan("t4");
        sweep("t4");

        // restart while a hit is pending, then again mid-scan
        do_scan("t5a");
        px_valid = 1'b1;
        px_x = 8'd50;
        tick();
        chk("t5_hit_up", hit, 1);
        model_scan();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("t5_hit_cleared", hit, 0);
        chk("t5_count_cleared", count, 0);
        chk("t5_idx_restart", oam_idx, 0);
        n = 0;
        while (oam_idx !== 6'd17 && n < 60) begin
            tick();
            n++;
        end
        chk("t5_reach_17", oam_idx, 17);
        chk("t5_mid_count", count, 2);
        chk("t5_no_hit_in_scan", hit, 0);
        px_valid = 1'b0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("t5_mid_count_cleared", count, 0);
        chk("t5_mid_idx_restart", oam_idx, 0);
        wait_done("t5b");
        sweep("t5b");

        // obj_en masks hits without disturbing the store
        do_scan("t6");
        obj_en = 1'b0;
        px_valid = 1'b1;
        px_x = 8'd50;
        tick();
        chk("t6_masked_a", hit, 0);
        tick();
        chk("t6_masked_b", hit, 0);
        obj_en = 1'b1;
        tick();
        chk("t6_unmask_hit", hit, 1);
        chk("t6_unmask_idx", hit_idx, 2);
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        chk("t6_ack_drop", hit, 0);
        tick();
        chk("t6_second_hit", hit, 1);
        chk("t6_second_idx", hit_idx, 7);
        obj_en = 1'b0;
        tick();
        chk("t6_mask_held_hit", hit, 0);
        obj_en = 1'b1;
        tick();
        chk("t6_rehit", hit, 1);
        chk("t6_rehit_idx", hit_idx, 7);
        chk("t6_rehit_row", hit_row, 3);
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        tick();
        chk("t6_all_served", hit, 0);
        px_valid = 1'b0;

        // stray acknowledge with no hit must not drop a slot
        do_scan("t7");
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        sweep("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
